// File: rtl/gl_vga_timing_monitor.sv
// Passive frame-geometry and pixel-checksum monitor for the GL VGA generator.
// Measures line/frame totals and active extents once per frame and flags lock when they repeat.
module gl_vga_timing_monitor #(
    parameter int CNT_W         = 12,
    parameter int STABLE_FRAMES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic             HBlank,
    input  logic             VBlank,
    input  logic [7:0]       vr,
    input  logic [7:0]       vg,
    input  logic [7:0]       vb,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic [23:0]      pix_sum,
    output logic             h_jitter,
    output logic             meas_valid,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       MATCH_TGT = 4'(STABLE_FRAMES);

    typedef enum logic [0:0] {
        ST_SEARCH  = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
        if (en && (val != CNT_MAX)) begin
            sat_inc = val + CNT_ONE;
        end else begin
            sat_inc = val;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;

    logic             prev_hblank_r;
    logic             ls_vblank_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hact_r;
    logic [CNT_W-1:0] vcnt_r;
    logic [CNT_W-1:0] vact_r;
    logic [23:0]      sum_r;
    logic [CNT_W-1:0] ref_len_r;
    logic             ref_valid_r;
    logic             jit_r;

    logic [CNT_W-1:0] h_total_r;
    logic [CNT_W-1:0] h_active_r;
    logic [CNT_W-1:0] v_total_r;
    logic [CNT_W-1:0] v_active_r;
    logic [23:0]      pix_sum_r;
    logic             h_jitter_r;
    logic             meas_valid_r;
    logic             locked_r;
    logic             have_prev_r;
    logic [3:0]       match_r;
    logic [3:0]       match_nxt_s;

    logic             line_start_s;
    logic             frame_start_s;
    logic             sat_s;
    logic             restart_s;
    logic             publish_s;
    logic             lost_s;
    logic             frame_jit_s;
    logic             geom_eq_s;
    logic [23:0]      pix_s;
    logic [23:0]      sum_add_s;

    assign line_start_s  = ce_pix & ~HBlank & prev_hblank_r;
    assign frame_start_s = line_start_s & ~VBlank & ls_vblank_r;
    assign sat_s         = ce_pix & ((hcnt_r == CNT_MAX) | (vcnt_r == CNT_MAX));
    assign pix_s         = {16'd0, vr} + {16'd0, vg} + {16'd0, vb};
    assign sum_add_s     = (~HBlank & ~VBlank) ? pix_s : 24'd0;

    // The line completing at a frame start is still part of the old frame's jitter check.
    assign frame_jit_s = jit_r | (ref_valid_r & (hcnt_r != ref_len_r));
    assign geom_eq_s   = have_prev_r
                       & (hcnt_r == h_total_r) & (hact_r == h_active_r)
                       & (vcnt_r == v_total_r) & (vact_r == v_active_r);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: saturation loses the frame and takes priority over a frame start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SEARCH: begin
                if (frame_start_s) begin
                    state_nxt_s = ST_MEASURE;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (sat_s) begin
                    state_nxt_s = ST_SEARCH;
                end else begin
                    state_nxt_s = ST_MEASURE;
                end
            end
            default: state_nxt_s = ST_SEARCH;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        restart_s = 1'b0;
        publish_s = 1'b0;
        lost_s    = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                restart_s = frame_start_s;
            end
            ST_MEASURE: begin
                lost_s    = sat_s;
                restart_s = frame_start_s & ~sat_s;
                publish_s = frame_start_s & ~sat_s;
            end
            default: begin
                restart_s = 1'b0;
                publish_s = 1'b0;
                lost_s    = 1'b0;
            end
        endcase
    end

    // Edge history used for line-start and frame-start detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_hblank_r <= 1'b0;
            ls_vblank_r   <= 1'b0;
        end else if (ce_pix) begin
            prev_hblank_r <= HBlank;
            if (line_start_s) begin
                ls_vblank_r <= VBlank;
            end
        end
    end

    // Running counters; the frame-start sample is sample 1 of line 1 of the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_r      <= '0;
            hact_r      <= '0;
            vcnt_r      <= '0;
            vact_r      <= '0;
            sum_r       <= 24'd0;
            ref_len_r   <= '0;
            ref_valid_r <= 1'b0;
            jit_r       <= 1'b0;
        end else if (ce_pix) begin
            if (restart_s) begin
                hcnt_r      <= CNT_ONE;
                hact_r      <= CNT_ONE;
                vcnt_r      <= CNT_ONE;
                vact_r      <= CNT_ONE;
                sum_r       <= pix_s;
                ref_valid_r <= 1'b0;
                jit_r       <= 1'b0;
            end else if (line_start_s) begin
                hcnt_r <= CNT_ONE;
                hact_r <= CNT_ONE;
                vcnt_r <= sat_inc(vcnt_r, 1'b1);
                vact_r <= sat_inc(vact_r, ~VBlank);
                sum_r  <= sum_r + sum_add_s;
                if (!ref_valid_r) begin
                    ref_len_r   <= hcnt_r;
                    ref_valid_r <= 1'b1;
                end else if (hcnt_r != ref_len_r) begin
                    jit_r <= 1'b1;
                end
            end else begin
                hcnt_r <= sat_inc(hcnt_r, 1'b1);
                hact_r <= sat_inc(hact_r, ~HBlank);
                sum_r  <= sum_r + sum_add_s;
            end
        end
    end

    // Measurement outputs, captured at each accepted frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_total_r    <= '0;
            h_active_r   <= '0;
            v_total_r    <= '0;
            v_active_r   <= '0;
            pix_sum_r    <= 24'd0;
            h_jitter_r   <= 1'b0;
            meas_valid_r <= 1'b0;
        end else begin
            meas_valid_r <= publish_s;
            if (publish_s) begin
                h_total_r  <= hcnt_r;
                h_active_r <= hact_r;
                v_total_r  <= vcnt_r;
                v_active_r <= vact_r;
                pix_sum_r  <= sum_r;
                h_jitter_r <= frame_jit_s;
            end
        end
    end

    // Match counter: compares new geometry against the measurement still held in the outputs.
    always_comb begin
        match_nxt_s = match_r;
        if (lost_s) begin
            match_nxt_s = 4'd0;
        end else if (publish_s) begin
            if (geom_eq_s && !frame_jit_s) begin
                if (match_r == MATCH_TGT) begin
                    match_nxt_s = match_r;
                end else begin
                    match_nxt_s = match_r + 4'd1;
                end
            end else begin
                match_nxt_s = 4'd0;
            end
        end else begin
            match_nxt_s = match_r;
        end
    end

    // Lock state; locked moves in the same cycle as meas_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_r     <= 4'd0;
            locked_r    <= 1'b0;
            have_prev_r <= 1'b0;
        end else begin
            match_r  <= match_nxt_s;
            locked_r <= (match_nxt_s == MATCH_TGT);
            if (lost_s) begin
                have_prev_r <= 1'b0;
            end else if (publish_s) begin
                have_prev_r <= 1'b1;
            end
        end
    end

    assign h_total    = h_total_r;
    assign h_active   = h_active_r;
    assign v_total    = v_total_r;
    assign v_active   = v_active_r;
    assign pix_sum    = pix_sum_r;
    assign h_jitter   = h_jitter_r;
    assign meas_valid = meas_valid_r;
    assign locked     = locked_r;

endmodule

// File: doc/gl_vga_timing_monitor.md
# gl_vga_timing_monitor

Passive measurement stage that sits directly downstream of the GL VGA timing/pattern generator, on the same `clk`. It samples `ce_pix`, `HBlank`, `VBlank` and the 8-bit RGB stream and measures per frame:
- total and active columns per line;
- total and active lines per frame;
- a checksum of active-area pixel data.

It declares `locked` once several consecutive frames match. Its outputs feed status/debug logic and let the bench check the generator's geometry and pattern without a frame grabber.

## Interface
Parameters:
- `CNT_W`, 12: width of all column/line counters and measurement outputs.
- `STABLE_FRAMES`, 3: number of consecutive identical measurements required to assert `locked` (valid range 1–15).

Ports:
- `clk`  in  1: pixel-domain clock (same clock as the generator).
- `reset`  in  1: synchronous, active-high reset.
- `ce_pix`  in  1: pixel enable; every input is sampled only on cycles where `ce_pix`=1.
- `HBlank`  in  1: horizontal blank from the generator.
- `VBlank`  in  1: vertical blank from the generator.
- `vr`, `vg`, `vb`  in  8 each: pixel colour.
- `h_total`  out  CNT_W: samples per line (last complete line of the last complete frame).
- `h_active`  out  CNT_W: samples with `HBlank`=0 in that line.
- `v_total`  out  CNT_W: lines per frame.
- `v_active`  out  CNT_W: lines whose line-start sample had `VBlank`=0.
- `pix_sum`  out  24: sum of `vr`+`vg`+`vb` over samples with `HBlank`=0 and `VBlank`=0, modulo 2^24.
- `h_jitter`  out  1: at least one line in the last frame had a different `h_total` than the frame's first line.
- `meas_valid`  out  1: one-`clk` pulse when the measurement outputs update.
- `locked`  out  1: geometry stable.

## Operation
- Sample: a `clk` cycle with `ce_pix`=1. Non-sample cycles change no state.
- Line start: a sample with `HBlank`=0 whose previous sample had `HBlank`=1.
- Frame start: a line start with `VBlank`=0 whose previous line start had `VBlank`=1.
- Running counters, all saturating at 2^CNT_W−1:
  - `hcnt`: samples since the last line start.
  - `hact`: active samples in the current line.
  - `vcnt`: line starts since the last frame start.
  - `vact`: active line starts in the current frame.
  - `sum`: running pixel checksum, wraps modulo 2^24.
- Line boundary: the length of the completed line is `hcnt`, counted from the previous line start inclusive to this one exclusive.
  - The first completed line of a frame is the reference length; any later line in the same frame with a different length sets the frame's jitter flag.
- State machine:
  - SEARCH (after reset): wait for the first frame start, then clear all counters and go to MEASURE. No outputs update.
  - MEASURE: count. At each frame start, register into the outputs:
    - `h_total`/`h_active` from the last completed line;
    - `v_total`, `v_active`, `pix_sum`, `h_jitter` for the frame just ended;
    - pulse `meas_valid`, then clear the running counters and stay in MEASURE.
  - If `hcnt` or `vcnt` reaches saturation, the frame is lost. Go to SEARCH, clear `locked` and the match counter, and do not pulse `meas_valid`.
- Lock:
  - Match counter: increments on each `meas_valid` whose four geometry values equal the previous measurement and whose `h_jitter`=0, saturating at `STABLE_FRAMES`. Any other `meas_valid` resets it to 0.
  - `locked` = (match counter == `STABLE_FRAMES`).
  - The first measurement after SEARCH has no predecessor, so the counter stays 0.
  - `pix_sum` does not affect lock.
- Reset mid-frame: all state returns to SEARCH and all outputs return to reset values on the next `clk`.

## Timing
- Reset values: all measurement outputs 0, `h_jitter`=0, `meas_valid`=0, `locked`=0, state SEARCH.
- Latency: outputs and `meas_valid` become valid on the `clk` edge after the frame-start sample (1 `clk`). `locked` updates in the same cycle as `meas_valid`.
- The frame-start sample itself counts as line 1 / sample 1 of the new frame, and its pixel goes into the new frame's sum.
- Minimum time from reset to first `meas_valid`: one partial frame plus one full frame.
- Simultaneous events:
  - Saturation wins over a frame start in the same sample.
  - `reset` wins over everything.

## Test plan
1. Generator defaults (800×520, active 640×480), `scandouble`=1 (`ce_pix` always 1). Expect:
   - first `meas_valid` within 2×416000 `clk`;
   - `h_total`=800, `h_active`=640, `v_total`=520, `v_active`=480, `h_jitter`=0.
2. Same stimulus, generator test pattern. Expect `pix_sum`=8486400 on every `meas_valid`, and `locked` rising on the 4th `meas_valid` (3 matches after the first).
3. `scandouble`=0 (`ce_pix` toggles). Expect identical measurements to scenario 1, with `meas_valid` spaced 832000 `clk` apart.
4. Hold `HBlank`=1 after lock. Expect `hcnt` to saturate at 4095 samples, `locked`→0, state SEARCH, and no `meas_valid` until two clean frame starts have occurred.
5. Synthetic stream with one 801-sample line mid-frame. Expect `h_jitter`=1 on that frame's `meas_valid`, `locked`→0, and relock after 3 further clean matching frames.
6. Assert `reset` for one `clk` mid-frame while locked. Expect all outputs 0 next `clk`, and the first `meas_valid` only after one partial and one full frame.
